// File: rtl/reg_file_read_port_if.sv
// Read-port bundle: request/address, register-array contents, write strobe and operand handshake.
// master drives requests and register-array state; slave is the read port itself.
interface reg_file_read_port_if #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NUM_REGS    = 32
);
  logic                            rd_req_i;
  logic [ADDR_WIDTH-1:0]           rs1_addr_i;
  logic [ADDR_WIDTH-1:0]           rs2_addr_i;
  logic [NUM_REGS*WORD_LENGTH-1:0] reg_bus_i;
  logic                            wr_en_i;
  logic [ADDR_WIDTH-1:0]           wr_addr_i;
  logic [WORD_LENGTH-1:0]          wr_data_i;
  logic                            rd_gnt_o;
  logic                            rd_valid_o;
  logic                            rd_ready_i;
  logic [WORD_LENGTH-1:0]          rd1_data_o;
  logic [WORD_LENGTH-1:0]          rd2_data_o;

  modport master (
    output rd_req_i, rs1_addr_i, rs2_addr_i, reg_bus_i,
           wr_en_i, wr_addr_i, wr_data_i, rd_ready_i,
    input  rd_gnt_o, rd_valid_o, rd1_data_o, rd2_data_o
  );

  modport slave (
    input  rd_req_i, rs1_addr_i, rs2_addr_i, reg_bus_i,
           wr_en_i, wr_addr_i, wr_data_i, rd_ready_i,
    output rd_gnt_o, rd_valid_o, rd1_data_o, rd2_data_o
  );
endinterface

// File: rtl/reg_file_read_port.sv
// Dual registered read port with write-through bypass and hold-time refresh.
// Optional macro REG_FILE_ZERO_REG_EN makes register 0 read as hardwired zero.
module reg_file_read_port #(
  parameter int unsigned WORD_LENGTH = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NUM_REGS    = 32
) (
  input logic              clk,
  input logic              reset,
  reg_file_read_port_if.slave rp
);
  localparam int unsigned W  = WORD_LENGTH;
  localparam int unsigned AW = ADDR_WIDTH;

  logic [W-1:0]  regs_c [NUM_REGS];
  logic          wr_hit_c;
  logic          gnt_c;
  logic [W-1:0]  cap1_c, cap2_c, ref1_c, ref2_c;

  logic          valid_q;
  logic [AW-1:0] rs1_q, rs2_q;
  logic [W-1:0]  rd1_q, rd2_q;

  // Unpack the flattened array; register 0 optionally forced to zero
  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_c[k] = rp.reg_bus_i[k*W +: W];
    end
`ifdef REG_FILE_ZERO_REG_EN
    regs_c[0] = '0;
`endif
  end

`ifdef REG_FILE_ZERO_REG_EN
  assign wr_hit_c = rp.wr_en_i && (rp.wr_addr_i != '0);
`else
  assign wr_hit_c = rp.wr_en_i;
`endif

  assign gnt_c = rp.rd_req_i && (!valid_q || rp.rd_ready_i);

  // Capture values (bypass on address match) and hold-refresh values per port
  always_comb begin
    cap1_c = regs_c[rp.rs1_addr_i];
    cap2_c = regs_c[rp.rs2_addr_i];
    ref1_c = rd1_q;
    ref2_c = rd2_q;
    if (wr_hit_c && (rp.wr_addr_i == rp.rs1_addr_i)) cap1_c = rp.wr_data_i;
    if (wr_hit_c && (rp.wr_addr_i == rp.rs2_addr_i)) cap2_c = rp.wr_data_i;
    if (wr_hit_c && (rp.wr_addr_i == rs1_q))         ref1_c = rp.wr_data_i;
    if (wr_hit_c && (rp.wr_addr_i == rs2_q))         ref2_c = rp.wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else if (gnt_c) begin
      valid_q <= 1'b1;
      rs1_q   <= rp.rs1_addr_i;
      rs2_q   <= rp.rs2_addr_i;
      rd1_q   <= cap1_c;
      rd2_q   <= cap2_c;
    end else if (valid_q && rp.rd_ready_i) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Held result tracks writes to its source registers
      rd1_q <= ref1_c;
      rd2_q <= ref2_c;
    end
  end

  assign rp.rd_gnt_o   = gnt_c;
  assign rp.rd_valid_o = valid_q;
  assign rp.rd1_data_o = rd1_q;
  assign rp.rd2_data_o = rd2_q;
endmodule
